// File: rtl/sobel_stream_grad.sv
// Streaming 3x3 Sobel gradient for a raster-order pixel stream.
// Two line buffers provide the upper rows of each column. A two-column history plus
// the incoming column forms the 3x3 window. Signed Gx/Gy are produced for every
// interior pixel through a single registered output with valid/ready flow control.
// Optional macro SOBEL_MAG_EN adds m_mag = sat(|Gx| + |Gy|).
module sobel_stream_grad #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned OUT_W = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [PIX_W-1:0]        s_pix,
  input  logic                    s_sof,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] m_gx,
  output logic signed [OUT_W-1:0] m_gy,
  output logic                    m_last
`ifdef SOBEL_MAG_EN
  ,
  output logic [OUT_W-1:0]        m_mag
`endif
);

  localparam int unsigned FullW = PIX_W + 3;
  localparam int unsigned ColW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [ColW-1:0] ColMax = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0] ColTwo = ColW'(2);
  localparam logic [RowW-1:0] RowTwo = RowW'(2);

  localparam int SatMax = (1 <<< (OUT_W - 1)) - 1;
  localparam int SatMin = -(1 <<< (OUT_W - 1));

  // Weighted column/row sum a + 2b + c, zero-extended into the signed full-precision width.
  function automatic logic signed [FullW-1:0] wsum(input logic [PIX_W-1:0] a,
                                                   input logic [PIX_W-1:0] b,
                                                   input logic [PIX_W-1:0] c);
    return $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
  endfunction

  // Clamp a full-precision value into OUT_W; a wider OUT_W just sign-extends.
  function automatic logic signed [OUT_W-1:0] sat(input logic signed [FullW-1:0] v);
    int vi;
    vi = int'(v);
    if (vi > SatMax) begin
      vi = SatMax;
    end else if (vi < SatMin) begin
      vi = SatMin;
    end
    return vi[OUT_W-1:0];
  endfunction

  logic [ColW-1:0] col_q, col_d, col_eff;
  logic [RowW-1:0] row_q, row_d, row_eff;
  logic            accept, gen_out, last_d;

  logic [PIX_W-1:0] lb_top [IMG_W];  // row - 2
  logic [PIX_W-1:0] lb_mid [IMG_W];  // row - 1
  logic [PIX_W-1:0] hist_q [3][2];   // two most recent window columns, [row][col]
  logic [PIX_W-1:0] win    [3][3];   // window including the column being accepted

  logic signed [FullW-1:0] gx_full, gy_full;

  logic                    valid_q, last_q;
  logic signed [OUT_W-1:0] gx_q, gy_q;

  assign s_ready = !valid_q || m_ready;
  assign accept  = s_valid && s_ready;

  // A start-of-frame pixel is position (0,0) whatever the counters say.
  assign col_eff = s_sof ? '0 : col_q;
  assign row_eff = s_sof ? '0 : row_q;

  assign gen_out = accept && (row_eff >= RowTwo) && (col_eff >= ColTwo);
  assign last_d  = (row_eff == RowMax) && (col_eff == ColMax);

  // Raster counter next state.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_eff == ColMax) begin
        col_d = '0;
        row_d = (row_eff == RowMax) ? '0 : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end
    end
  end

  // Assemble the 3x3 window: history columns on the left, new column on the right.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win[r][0] = hist_q[r][0];
      win[r][1] = hist_q[r][1];
    end
    win[0][2] = lb_top[col_eff];
    win[1][2] = lb_mid[col_eff];
    win[2][2] = s_pix;
  end

  // Gx is left minus right, Gy is top minus bottom.
  always_comb begin
    gx_full = wsum(win[0][0], win[1][0], win[2][0]) - wsum(win[0][2], win[1][2], win[2][2]);
    gy_full = wsum(win[0][0], win[0][1], win[0][2]) - wsum(win[2][0], win[2][1], win[2][2]);
  end

  // Line buffers and window history; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[col_eff] <= lb_mid[col_eff];
      lb_mid[col_eff] <= s_pix;
      for (int r = 0; r < 3; r++) begin
        hist_q[r][0] <= win[r][1];
        hist_q[r][1] <= win[r][2];
      end
    end
  end

  // Raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Output register: loads on interior accepts, otherwise drains when taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      gx_q    <= '0;
      gy_q    <= '0;
      last_q  <= 1'b0;
    end else if (gen_out) begin
      valid_q <= 1'b1;
      gx_q    <= sat(gx_full);
      gy_q    <= sat(gy_full);
      last_q  <= last_d;
    end else if (m_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign m_valid = valid_q;
  assign m_gx    = gx_q;
  assign m_gy    = gy_q;
  assign m_last  = last_q;

`ifdef SOBEL_MAG_EN
  localparam int MagMax = (1 <<< OUT_W) - 1;

  logic [OUT_W-1:0] mag_d, mag_q;

  // |Gx| + |Gy| from full-precision values, clamped to the unsigned output range.
  always_comb begin
    int ax, ay, mi;
    ax = int'(gx_full);
    ay = int'(gy_full);
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
    mi = ax + ay;
    if (mi > MagMax) mi = MagMax;
    mag_d = mi[OUT_W-1:0];
  end

  // Magnitude register shares the gradient handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q <= '0;
    end else if (gen_out) begin
      mag_q <= mag_d;
    end
  end

  assign m_mag = mag_q;
`endif

endmodule

// File: tb/tb_sobel_stream_grad.sv
// Scoreboard bench for sobel_stream_grad on a 6x6 image. A full-precision instance
// (OUT_W=11) and a saturating instance (OUT_W=10) share one input stream; a frame-array
// reference model pushes expectations on each accept and the monitor pops them on output.
module tb_sobel_stream_grad;

  localparam int PW = 8;
  localparam int W  = 6;
  localparam int H  = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_valid = 1'b0;
  logic          s_sof   = 1'b0;
  logic [PW-1:0] s_pix   = '0;
  logic          m_ready = 1'b1;

  logic               s_ready, m_valid, m_last;
  logic signed [10:0] m_gx, m_gy;
  logic               sat_s_ready, sat_valid, sat_last;
  logic signed [9:0]  sat_gx, sat_gy;
`ifdef SOBEL_MAG_EN
  logic [10:0] m_mag;
  logic [9:0]  sat_mag;
`endif

  sobel_stream_grad #(.PIX_W(PW), .IMG_W(W), .IMG_H(H), .OUT_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_pix(s_pix),
    .s_sof(s_sof), .m_valid(m_valid), .m_ready(m_ready), .m_gx(m_gx), .m_gy(m_gy),
    .m_last(m_last)
`ifdef SOBEL_MAG_EN
    , .m_mag(m_mag)
`endif
  );

  sobel_stream_grad #(.PIX_W(PW), .IMG_W(W), .IMG_H(H), .OUT_W(10)) dut_sat (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(sat_s_ready), .s_pix(s_pix),
    .s_sof(s_sof), .m_valid(sat_valid), .m_ready(m_ready), .m_gx(sat_gx), .m_gy(sat_gy),
    .m_last(sat_last)
`ifdef SOBEL_MAG_EN
    , .m_mag(sat_mag)
`endif
  );

  typedef struct {
    int gx;
    int gy;
    bit last;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;

  int img[H][W];
  int mr = 0, mc = 0;
  int n_outs = 0, n_last = 0, n_gx_edge = 0, n_sat_edge = 0, n_gy_edge = 0, n_stall = 0;
  bit stalled = 1'b0;
  int hold_gx, hold_gy, hold_last;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // 0: flat 100, 1: vertical edge (cols 3-5 = 255), 2: horizontal edge (rows 3-5 = 200)
  function automatic int pixel(input int kind, input int r, input int c);
    case (kind)
      0:       return 100;
      1:       return (c >= 3) ? 255 : 0;
      default: return (r >= 3) ? 200 : 0;
    endcase
  endfunction

  // Monitor: check outputs against the scoreboard, then model any accept at the next edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      mr = 0;
      mc = 0;
      stalled = 1'b0;
    end else begin
      if (stalled && m_valid) begin
        check("hold_gx", m_gx, hold_gx);
        check("hold_gy", m_gy, hold_gy);
        check("hold_last", m_last, hold_last);
      end
      if (m_valid && !m_ready) begin
        check("s_ready_stall", s_ready, 0);
        n_stall++;
      end
      stalled   = m_valid && !m_ready;
      hold_gx   = m_gx;
      hold_gy   = m_gy;
      hold_last = m_last;

      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("gx", m_gx, e.gx);
          check("gy", m_gy, e.gy);
          check("last", m_last, e.last);
          check("sat_valid", sat_valid, 1);
          check("sat_gx", sat_gx, clamp(e.gx, -512, 511));
          check("sat_gy", sat_gy, clamp(e.gy, -512, 511));
`ifdef SOBEL_MAG_EN
          check("mag", m_mag, clamp(iabs(e.gx) + iabs(e.gy), 0, 2047));
          check("sat_mag", sat_mag, clamp(iabs(e.gx) + iabs(e.gy), 0, 1023));
`endif
          n_outs++;
          if (m_gx == -1020) n_gx_edge++;
          if (sat_gx == -512) n_sat_edge++;
          if (m_gy == -800) n_gy_edge++;
          if (m_last) n_last++;
        end
      end

      if (s_valid && s_ready) begin
        if (s_sof) begin
          mr = 0;
          mc = 0;
        end
        img[mr][mc] = int'(s_pix);
        if (mr >= 2 && mc >= 2) begin
          e.gx = (img[mr-2][mc-2] + 2 * img[mr-1][mc-2] + img[mr][mc-2])
               - (img[mr-2][mc] + 2 * img[mr-1][mc] + img[mr][mc]);
          e.gy = (img[mr-2][mc-2] + 2 * img[mr-2][mc-1] + img[mr-2][mc])
               - (img[mr][mc-2] + 2 * img[mr][mc-1] + img[mr][mc]);
          e.last = (mr == H - 1) && (mc == W - 1);
          sb.push_back(e);
        end
        mc++;
        if (mc == W) begin
          mc = 0;
          mr++;
          if (mr == H) mr = 0;
        end
      end
    end
  end

  // Present one pixel until accepted; returns 1ns after the accepting edge.
  task automatic send_pix(input int pix, input bit sof);
    int  tries = 0;
    bit  ok;
    s_valid = 1'b1;
    s_pix   = pix[PW-1:0];
    s_sof   = sof;
    do begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!ok && tries < 200);
    if (!ok) check("send_timeout", 0, 1);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_frame(input int kind, input int npix, input bit first_sof);
    for (int i = 0; i < npix; i++) begin
      send_pix(pixel(kind, i / W, i % W), first_sof && (i == 0));
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || m_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  int b_outs, b_last, b_gx, b_sat, b_gy;

  task automatic mark();
    b_outs = n_outs;
    b_last = n_last;
    b_gx   = n_gx_edge;
    b_sat  = n_sat_edge;
    b_gy   = n_gy_edge;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_gx", m_gx, 0);
    check("rst_m_gy", m_gy, 0);
    check("rst_m_last", m_last, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Flat image
    mark();
    send_frame(0, W * H, 1'b0);
    drain();
    check("flat_count", n_outs - b_outs, 16);
    check("flat_last_count", n_last - b_last, 1);

    // Vertical edge with a 5-cycle downstream stall mid-frame
    mark();
    fork
      send_frame(1, W * H, 1'b0);
      begin
        repeat (20) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    drain();
    check("vedge_count", n_outs - b_outs, 16);
    check("vedge_gx_m1020", n_gx_edge - b_gx, 8);
    check("vedge_sat_m512", n_sat_edge - b_sat, 8);
    check("stall_seen", int'(n_stall > 0), 1);
    check("vedge_last_count", n_last - b_last, 1);

    // Partial frame up to (3,1); (3,2) carries s_sof and starts a horizontal-edge frame
    send_frame(1, 3 * W + 2, 1'b0);
    mark();
    send_frame(2, W * H, 1'b1);
    drain();
    check("resync_count", n_outs - b_outs, 16);
    check("resync_gy_m800", n_gy_edge - b_gy, 8);
    check("resync_last_count", n_last - b_last, 1);

    // Asynchronous reset right after pixel (2,4) is accepted
    send_frame(1, 2 * W + 5, 1'b0);
    check("pre_reset_valid", m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", m_valid, 0);
    check("async_rst_gx", m_gx, 0);
    check("async_rst_s_ready", s_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mark();
    send_frame(0, W * H, 1'b0);
    drain();
    check("post_rst_count", n_outs - b_outs, 16);
    check("post_rst_last_count", n_last - b_last, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
